axi_l_slave_bfm: RTL and testbench

//   Simulation-only AXI-Lite responder (slave BFM) backed by a word-addressed memory model.

---
 rtl/axi_l_slave_bfm_if.sv | 38 +++
 rtl/axi_l_slave_bfm.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_l_slave_bfm.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_l_slave_bfm_if.sv
// AXI-Lite bus bundle between a master and the axi_l_slave_bfm responder.
interface axi_l_slave_bfm_if #(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8
) ();
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [MASK_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport slave (
      input  araddr, arprot, arvalid, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             rready,
      output arready, awready, wready, bresp, bvalid, rdata, rresp, rvalid
   );

   modport master (
      output araddr, arprot, arvalid, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             rready,
      input  arready, awready, wready, bresp, bvalid, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_l_slave_bfm.sv
// AXI-Lite responder backed by a word-addressed memory; one outstanding read and one
// outstanding write, independent channels, all handshake outputs registered.
module axi_l_slave_bfm #(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned MEM_AW     = 10,
   parameter int unsigned RD_LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   axi_l_slave_bfm_if.slave   bus,
   output logic [31:0]        wr_cnt,
   output logic [31:0]        rd_cnt
);
   localparam int unsigned LSB   = $clog2(MASK_WIDTH);
   localparam int unsigned DEPTH = 1 << MEM_AW;
   localparam int unsigned CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   typedef enum logic {WIdle, WResp} w_state_e;
   typedef enum logic [1:0] {RIdle, RWait, RData} r_state_e;

   function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
      return (addr >> (LSB + MEM_AW)) != '0;
   endfunction

   // Zeroed once at time 0; reset deliberately leaves contents alone.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

   w_state_e              w_state_q, w_state_d;
   logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic                  awready_q, awready_d, wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [MEM_AW-1:0]     aw_idx_q, aw_idx_d;
   logic                  aw_oor_q, aw_oor_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [MASK_WIDTH-1:0] wstrb_q, wstrb_d;
   logic [31:0]           wr_cnt_q, wr_cnt_d;
   logic                  mem_we;

   r_state_e              r_state_q, r_state_d;
   logic                  arready_q, arready_d;
   logic [MEM_AW-1:0]     ar_idx_q, ar_idx_d;
   logic                  ar_oor_q, ar_oor_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  rvalid_q, rvalid_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [31:0]           rd_cnt_q, rd_cnt_d;

   logic unused_bits;
   assign unused_bits = ^{bus.arprot, bus.awprot, bus.araddr[LSB-1:0], bus.awaddr[LSB-1:0]};

   always_comb begin
      w_state_d = w_state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      aw_idx_d  = aw_idx_q;
      aw_oor_d  = aw_oor_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      wr_cnt_d  = wr_cnt_q;
      mem_we    = 1'b0;
      case (w_state_q)
         WIdle: begin
            if (aw_done_q && w_done_q) begin
               mem_we    = ~aw_oor_q;
               bvalid_d  = 1'b1;
               bresp_d   = aw_oor_q ? 2'b10 : 2'b00;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b0;
               w_state_d = WResp;
            end else begin
               if (bus.awvalid && awready_q) begin
                  aw_done_d = 1'b1;
                  aw_idx_d  = bus.awaddr[LSB +: MEM_AW];
                  aw_oor_d  = out_of_range(bus.awaddr);
               end
               if (bus.wvalid && wready_q) begin
                  w_done_d = 1'b1;
                  wdata_d  = bus.wdata;
                  wstrb_d  = bus.wstrb;
               end
               // Readys also come up here the cycle after reset release.
               awready_d = ~aw_done_d;
               wready_d  = ~w_done_d;
            end
         end
         WResp: begin
            if (bus.bready) begin
               bvalid_d  = 1'b0;
               bresp_d   = 2'b00;
               wr_cnt_d  = wr_cnt_q + 32'd1;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               w_state_d = WIdle;
            end
         end
         default: w_state_d = WIdle;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      ar_idx_d  = ar_idx_q;
      ar_oor_d  = ar_oor_q;
      cnt_d     = cnt_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      rd_cnt_d  = rd_cnt_q;
      case (r_state_q)
         RIdle: begin
            if (bus.arvalid && arready_q) begin
               ar_idx_d  = bus.araddr[LSB +: MEM_AW];
               ar_oor_d  = out_of_range(bus.araddr);
               arready_d = 1'b0;
               cnt_d     = CNT_W'(RD_LATENCY - 1);
               r_state_d = RWait;
            end else begin
               arready_d = 1'b1;
            end
         end
         RWait: begin
            if (cnt_q == '0) begin
               // Registered sample: a commit on the same edge is not yet visible.
               rdata_d   = ar_oor_q ? '0 : mem_q[ar_idx_q];
               rresp_d   = ar_oor_q ? 2'b10 : 2'b00;
               rvalid_d  = 1'b1;
               r_state_d = RData;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RData: begin
            if (bus.rready) begin
               rvalid_d  = 1'b0;
               rdata_d   = '0;
               rresp_d   = 2'b00;
               rd_cnt_d  = rd_cnt_q + 32'd1;
               arready_d = 1'b1;
               r_state_d = RIdle;
            end
         end
         default: r_state_d = RIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= WIdle;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         aw_idx_q  <= '0;
         aw_oor_q  <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wr_cnt_q  <= '0;
         r_state_q <= RIdle;
         arready_q <= 1'b0;
         ar_idx_q  <= '0;
         ar_oor_q  <= 1'b0;
         cnt_q     <= '0;
         rvalid_q  <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= '0;
         rd_cnt_q  <= '0;
      end else begin
         w_state_q <= w_state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         aw_idx_q  <= aw_idx_d;
         aw_oor_q  <= aw_oor_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wr_cnt_q  <= wr_cnt_d;
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         ar_idx_q  <= ar_idx_d;
         ar_oor_q  <= ar_oor_d;
         cnt_q     <= cnt_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         rd_cnt_q  <= rd_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
            if (wstrb_q[i]) mem_q[aw_idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
         end
      end
   end

   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;
   assign bus.arready = arready_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rresp   = rresp_q;
   assign bus.rdata   = rdata_q;
   assign wr_cnt      = wr_cnt_q;
   assign rd_cnt      = rd_cnt_q;
endmodule

// File: tb/tb_axi_l_slave_bfm.sv
// Directed bench for axi_l_slave_bfm: inputs driven and outputs sampled on falling edges.
module tb_axi_l_slave_bfm;
   localparam int unsigned DW     = 512;
   localparam int unsigned AW     = 64;
   localparam int unsigned MW     = 64;
   localparam int unsigned MEM_AW = 10;
   localparam int unsigned RD_LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] wr_cnt, rd_cnt;
   int          n_checks = 0;
   int          n_err = 0;

   axi_l_slave_bfm_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_WIDTH(MW)) bus ();

   axi_l_slave_bfm #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_WIDTH(MW), .MEM_AW(MEM_AW), .RD_LATENCY(RD_LAT)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [MW-1:0] strb, output logic [1:0] resp);
      logic aw_pend, w_pend, aw_go, w_go;
      int   n;
      aw_pend = 1'b1; w_pend = 1'b1; n = 0;
      bus.awaddr = addr; bus.awvalid = 1'b1;
      bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
      while ((aw_pend || w_pend) && n < 50) begin
         aw_go = aw_pend & bus.awready;
         w_go  = w_pend & bus.wready;
         @(negedge clk); n++;
         if (aw_go) begin aw_pend = 1'b0; bus.awvalid = 1'b0; end
         if (w_go)  begin w_pend = 1'b0;  bus.wvalid = 1'b0;  end
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
      chk_b("write_in_time", n < 50, 1'b1);
      resp = bus.bresp;
      bus.bready = 1'b1; @(negedge clk); bus.bready = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp, output int lat);
      int n;
      n = 0;
      bus.araddr = addr; bus.arvalid = 1'b1;
      while (!bus.arready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk); bus.arvalid = 1'b0;
      lat = 0;
      while (!bus.rvalid && lat < 50) begin @(negedge clk); lat++; end
      chk_b("read_in_time", (n < 50) && (lat < 50), 1'b1);
      data = bus.rdata; resp = bus.rresp;
      bus.rready = 1'b1; @(negedge clk); bus.rready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish expected finish within 1ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] rd, pat_a5, pat_80, pat_c0;
      logic [1:0]    resp;
      int            lat;
      pat_a5 = {64{8'hA5}};
      pat_80 = {{63{8'hFF}}, 8'h80};
      pat_c0 = {8{64'hDEAD_BEEF_0123_4567}};
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 1'b0;
      bus.bready = 1'b0; bus.rready = 1'b0;

      // Reset and idle
      repeat (3) @(negedge clk);
      chk_b("rst_awready", bus.awready, 1'b0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk_b("idle_awready", bus.awready, 1'b1);
      chk_b("idle_wready", bus.wready, 1'b1);
      chk_b("idle_arready", bus.arready, 1'b1);
      chk_b("idle_bvalid", bus.bvalid, 1'b0);
      chk_b("idle_rvalid", bus.rvalid, 1'b0);
      chk_w("idle_wr_cnt", 512'(wr_cnt), 512'd0);
      chk_w("idle_rd_cnt", 512'(rd_cnt), 512'd0);

      // Full-strobe write then read back
      do_write(64'h40, pat_a5, '1, resp);
      chk_w("w40_bresp", 512'(resp), 512'd0);
      do_read(64'h40, rd, resp, lat);
      chk_w("r40_latency", 512'(lat), 512'd2);
      chk_w("r40_rdata", rd, pat_a5);
      chk_w("r40_rresp", 512'(resp), 512'd0);
      chk_w("r40_rdata_cleared", bus.rdata, 512'd0);
      chk_w("r40_wr_cnt", 512'(wr_cnt), 512'd1);
      chk_w("r40_rd_cnt", 512'(rd_cnt), 512'd1);

      // W three cycles ahead of AW, single byte strobe
      bus.wdata = pat_80; bus.wstrb = 64'h1; bus.wvalid = 1'b1;
      @(negedge clk); bus.wvalid = 1'b0;
      chk_b("wfirst_wready", bus.wready, 1'b0);
      chk_b("wfirst_awready", bus.awready, 1'b1);
      repeat (2) @(negedge clk);
      bus.awaddr = 64'h80; bus.awvalid = 1'b1;
      @(negedge clk); bus.awvalid = 1'b0;
      chk_b("wfirst_bvalid_early", bus.bvalid, 1'b0);
      @(negedge clk);
      chk_b("wfirst_bvalid", bus.bvalid, 1'b1);
      chk_w("wfirst_bresp", 512'(bus.bresp), 512'd0);
      bus.bready = 1'b1; @(negedge clk); bus.bready = 1'b0;
      do_read(64'h80, rd, resp, lat);
      chk_w("r80_byte0", rd, 512'h80);
      do_read(64'h83, rd, resp, lat);
      chk_w("r83_low_bits_ignored", rd, 512'h80);

      // bready held low with a second AW pending
      bus.awaddr = 64'hC0; bus.awvalid = 1'b1;
      bus.wdata = pat_c0; bus.wstrb = '1; bus.wvalid = 1'b1;
      @(negedge clk); bus.wvalid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         chk_b("bhold_bvalid", bus.bvalid, 1'b1);
         chk_b("bhold_awready", bus.awready, 1'b0);
         chk_b("bhold_wready", bus.wready, 1'b0);
         @(negedge clk);
      end
      chk_w("bhold_wr_cnt", 512'(wr_cnt), 512'd2);
      bus.awvalid = 1'b0; bus.bready = 1'b1;
      @(negedge clk); bus.bready = 1'b0;
      chk_w("bhold_wr_cnt_after", 512'(wr_cnt), 512'd3);

      // rready held low with a second AR pending
      bus.araddr = 64'hC0; bus.arvalid = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         chk_b("rhold_rvalid", bus.rvalid, 1'b1);
         chk_w("rhold_rdata", bus.rdata, pat_c0);
         chk_b("rhold_arready", bus.arready, 1'b0);
         @(negedge clk);
      end
      bus.arvalid = 1'b0; bus.rready = 1'b1;
      @(negedge clk); bus.rready = 1'b0;
      chk_w("rhold_rd_cnt", 512'(rd_cnt), 512'd4);
      chk_w("rhold_rdata_cleared", bus.rdata, 512'd0);

      // Out of range: first address past the memory
      do_write(64'h1 << 16, {DW{1'b1}}, '1, resp);
      chk_w("oor_bresp", 512'(resp), 512'd2);
      do_read(64'h1 << 16, rd, resp, lat);
      chk_w("oor_rresp", 512'(resp), 512'd2);
      chk_w("oor_rdata", rd, 512'd0);
      do_read(64'h0, rd, resp, lat);
      chk_w("oor_word0_unchanged", rd, 512'd0);
      chk_w("oor_wr_cnt", 512'(wr_cnt), 512'd4);
      chk_w("oor_rd_cnt", 512'(rd_cnt), 512'd6);

      // Reset during read latency
      bus.araddr = 64'h80; bus.arvalid = 1'b1;
      @(negedge clk); bus.arvalid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk_b("rstr_arready", bus.arready, 1'b0);
      chk_b("rstr_rvalid", bus.rvalid, 1'b0);
      chk_w("rstr_rdata", bus.rdata, 512'd0);
      chk_w("rstr_wr_cnt", 512'(wr_cnt), 512'd0);
      chk_w("rstr_rd_cnt", 512'(rd_cnt), 512'd0);
      rst = 1'b0;
      @(negedge clk);

      // Reset after AW-only capture
      bus.awaddr = 64'h40; bus.awvalid = 1'b1;
      @(negedge clk); bus.awvalid = 1'b0;
      chk_b("awonly_awready", bus.awready, 1'b0);
      chk_b("awonly_wready", bus.wready, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk_b("rstw_awready", bus.awready, 1'b0);
      chk_b("rstw_wready", bus.wready, 1'b0);
      chk_b("rstw_bvalid", bus.bvalid, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      do_write(64'h100, pat_c0, '1, resp);
      chk_w("post_rst_bresp", 512'(resp), 512'd0);
      do_read(64'h40, rd, resp, lat);
      chk_w("post_rst_old_data", rd, pat_a5);
      do_read(64'h100, rd, resp, lat);
      chk_w("post_rst_new_word", rd, pat_c0);
      chk_w("post_rst_wr_cnt", 512'(wr_cnt), 512'd1);
      chk_w("post_rst_rd_cnt", 512'(rd_cnt), 512'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
